// File: rtl/imem_pkg.sv
// Shared state encoding and default widths for the instruction-memory fetch controller.
package imem_pkg;

    localparam int ADDR_W_DEF     = 24;
    localparam int DATA_W_DEF     = 24;
    localparam int IMEM_DEPTH_DEF = 256;

    typedef enum logic [1:0] {
        ST_LOAD = 2'b00,
        ST_RUN  = 2'b01,
        ST_HALT = 2'b10
    } state_t;

endpackage

// File: rtl/pc_next_logic.sv
// Next-PC priority mux (halt > stall > branch > increment) with address range checks.
// Purely combinational; no flow control.
module pc_next_logic
    import imem_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int IMEM_DEPTH = IMEM_DEPTH_DEF,
    parameter int PC_STEP    = 1
) (
    input  logic [ADDR_W-1:0] i_pc,
    input  logic              i_halt,
    input  logic              i_stall,
    input  logic              i_branch_taken,
    input  logic [ADDR_W-1:0] i_branch_target,
    output logic [ADDR_W-1:0] o_pc_next,
    output logic              o_next_fault,
    output logic              o_cur_fault
);

    // One extra bit so a depth equal to 2^ADDR_W never faults.
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(IMEM_DEPTH);

    always_comb begin
        o_pc_next = i_pc + ADDR_W'(PC_STEP);
        if (i_halt || i_stall) begin
            o_pc_next = i_pc;
        end else if (i_branch_taken) begin
            o_pc_next = i_branch_target;
        end
    end

    assign o_next_fault = ({1'b0, o_pc_next} >= DEPTH_L);
    assign o_cur_fault  = ({1'b0, i_pc} >= DEPTH_L);

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Owns the PC and muxes the single InstructionMemory port between fetch and the loader.
// PC/state update one cycle after the controlling input; no backpressure, loader writes land same cycle.
module imem_fetch_ctrl
    import imem_pkg::*;
#(
    parameter int                ADDR_W     = ADDR_W_DEF,
    parameter int                DATA_W     = DATA_W_DEF,
    parameter int                IMEM_DEPTH = IMEM_DEPTH_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter int                PC_STEP    = 1,
    parameter bit                BOOT_LOAD  = 1'b1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_load_vld,
    input  logic [ADDR_W-1:0] i_load_addr,
    input  logic [DATA_W-1:0] i_load_dat,
    input  logic              i_load_done,
    input  logic              i_load_req,
    input  logic              i_stall,
    input  logic              i_branch_taken,
    input  logic [ADDR_W-1:0] i_branch_target,
    input  logic              i_halt,
    input  logic              i_resume,
    output logic [ADDR_W-1:0] o_imem_addr,
    output logic [DATA_W-1:0] o_imem_wr_dat,
    output logic              o_imem_we,
    output logic [ADDR_W-1:0] o_pc,
    output logic              o_fetch_vld,
    output logic [1:0]        o_state,
    output logic [ADDR_W-1:0] o_load_count,
    output logic              o_addr_fault
);

    localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(IMEM_DEPTH);
    localparam logic [ADDR_W-1:0] CNT_MAX = '1;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pc_nxt;
    logic [ADDR_W-1:0] r_load_count;
    logic [ADDR_W-1:0] w_cnt_nxt;
    logic              r_addr_fault;
    logic              w_fault_nxt;

    logic [ADDR_W-1:0] w_pc_next;
    logic              w_next_fault;
    logic              w_cur_fault;
    logic              w_in_load;
    logic              w_in_run;
    logic              w_load_in_range;

    pc_next_logic #(
        .ADDR_W     (ADDR_W),
        .IMEM_DEPTH (IMEM_DEPTH),
        .PC_STEP    (PC_STEP)
    ) u_pc_next (
        .i_pc            (r_pc),
        .i_halt          (i_halt),
        .i_stall         (i_stall),
        .i_branch_taken  (i_branch_taken),
        .i_branch_target (i_branch_target),
        .o_pc_next       (w_pc_next),
        .o_next_fault    (w_next_fault),
        .o_cur_fault     (w_cur_fault)
    );

    assign w_in_load       = (r_state == ST_LOAD);
    assign w_in_run        = (r_state == ST_RUN);
    assign w_load_in_range = ({1'b0, i_load_addr} < DEPTH_L);

    assign o_imem_addr   = w_in_load ? i_load_addr : r_pc;
    assign o_imem_wr_dat = i_load_dat;
    assign o_imem_we     = i_load_vld & w_in_load & w_load_in_range;
    assign o_fetch_vld   = w_in_run & ~i_stall & ~w_cur_fault;
    assign o_pc          = r_pc;
    assign o_state       = r_state;
    assign o_load_count  = r_load_count;
    assign o_addr_fault  = r_addr_fault;

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_cnt_nxt   = r_load_count;
        w_fault_nxt = r_addr_fault;
        case (r_state)
            ST_LOAD: begin
                if (i_load_vld) begin
                    if (!w_load_in_range) begin
                        w_fault_nxt = 1'b1;
                    end else if (r_load_count != CNT_MAX) begin
                        w_cnt_nxt = r_load_count + ADDR_W'(1);
                    end
                end
                if (i_load_done) begin
                    w_state_nxt = ST_RUN;
                    w_pc_nxt    = RESET_PC;
                end
            end
            ST_RUN: begin
                // A PC already out of range must not fetch or advance.
                if (w_cur_fault) begin
                    w_fault_nxt = 1'b1;
                    w_state_nxt = ST_HALT;
                end else begin
                    w_pc_nxt = w_pc_next;
                    if (i_halt) begin
                        w_state_nxt = ST_HALT;
                    end else if (w_next_fault) begin
                        w_fault_nxt = 1'b1;
                        w_state_nxt = ST_HALT;
                    end
                end
            end
            ST_HALT: begin
                if (i_load_req) begin
                    w_state_nxt = ST_LOAD;
                    w_cnt_nxt   = '0;
                end else if (i_resume) begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: w_state_nxt = ST_HALT;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            if (BOOT_LOAD) begin
                r_state <= ST_LOAD;
            end else begin
                r_state <= ST_RUN;
            end
            r_pc         <= RESET_PC;
            r_load_count <= '0;
            r_addr_fault <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_load_count <= w_cnt_nxt;
            r_addr_fault <= w_fault_nxt;
        end
    end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Scoreboard bench: two controllers (depth 256 and depth 16) share one stimulus stream.
module tb_imem_fetch_ctrl;

    localparam int M_LOAD = 0;
    localparam int M_RUN  = 1;
    localparam int M_HALT = 2;
    localparam int unsigned WRAP = 32'h0100_0000;
    localparam int unsigned CMAX = 32'h00FF_FFFF;

    logic        clk = 1'b0;
    logic        rst_n, load_vld, load_done, load_req, stall, br, halt, resume;
    logic [23:0] load_addr, load_dat, br_tgt;

    logic [23:0] o0_addr, o0_wdat, o0_pc, o0_cnt, o1_addr, o1_wdat, o1_pc, o1_cnt;
    logic        o0_we, o0_fetch, o0_fault, o1_we, o1_fetch, o1_fault;
    logic [1:0]  o0_state, o1_state;

    initial forever #5 clk = ~clk;

    imem_fetch_ctrl u_dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_load_vld(load_vld), .i_load_addr(load_addr),
        .i_load_dat(load_dat), .i_load_done(load_done), .i_load_req(load_req),
        .i_stall(stall), .i_branch_taken(br), .i_branch_target(br_tgt), .i_halt(halt),
        .i_resume(resume), .o_imem_addr(o0_addr), .o_imem_wr_dat(o0_wdat),
        .o_imem_we(o0_we), .o_pc(o0_pc), .o_fetch_vld(o0_fetch), .o_state(o0_state),
        .o_load_count(o0_cnt), .o_addr_fault(o0_fault)
    );

    imem_fetch_ctrl #(.IMEM_DEPTH(16)) u_dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_load_vld(load_vld), .i_load_addr(load_addr),
        .i_load_dat(load_dat), .i_load_done(load_done), .i_load_req(load_req),
        .i_stall(stall), .i_branch_taken(br), .i_branch_target(br_tgt), .i_halt(halt),
        .i_resume(resume), .o_imem_addr(o1_addr), .o_imem_wr_dat(o1_wdat),
        .o_imem_we(o1_we), .o_pc(o1_pc), .o_fetch_vld(o1_fetch), .o_state(o1_state),
        .o_load_count(o1_cnt), .o_addr_fault(o1_fault)
    );

    typedef struct {
        int          inst;
        bit          chk;
        logic        we;
        logic [23:0] addr;
        logic [23:0] wdat;
        logic        fetch;
    } comb_e;

    typedef struct {
        int          inst;
        bit          chk;
        logic [1:0]  state;
        logic [23:0] pc;
        logic [23:0] cnt;
        logic        fault;
    } reg_e;

    comb_e cq[$];
    reg_e  rq[$];

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: one entry per controller instance.
    int          depth[2] = '{256, 16};
    int          m_mode[2];
    int unsigned m_pc[2];
    int unsigned m_cnt[2];
    bit          m_fault[2];
    bit          m_known[2] = '{1'b0, 1'b0};

    task automatic check(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, inst, act, exp, $time);
        end
    endtask

    task automatic advance(input int k);
        if (!rst_n) begin
            m_mode[k]  = M_LOAD;
            m_pc[k]    = 0;
            m_cnt[k]   = 0;
            m_fault[k] = 1'b0;
            m_known[k] = 1'b1;
            return;
        end
        if (!m_known[k]) return;
        case (m_mode[k])
            M_LOAD: begin
                if (load_vld) begin
                    if (load_addr >= depth[k]) m_fault[k] = 1'b1;
                    else if (m_cnt[k] < CMAX) m_cnt[k] = m_cnt[k] + 1;
                end
                if (load_done) begin
                    m_mode[k] = M_RUN;
                    m_pc[k]   = 0;
                end
            end
            M_RUN: begin
                if (m_pc[k] >= depth[k]) begin
                    m_fault[k] = 1'b1;
                    m_mode[k]  = M_HALT;
                end else if (halt) begin
                    m_mode[k] = M_HALT;
                end else if (!stall) begin
                    m_pc[k] = br ? int'(br_tgt) : (m_pc[k] + 1) % WRAP;
                    if (m_pc[k] >= depth[k]) begin
                        m_fault[k] = 1'b1;
                        m_mode[k]  = M_HALT;
                    end
                end
            end
            default: begin
                if (load_req) begin
                    m_mode[k] = M_LOAD;
                    m_cnt[k]  = 0;
                end else if (resume) begin
                    m_mode[k] = M_RUN;
                end
            end
        endcase
    endtask

    // Issue the currently driven inputs for one cycle and queue the expected response.
    task automatic step();
        comb_e ce;
        reg_e  re;
        for (int k = 0; k < 2; k++) begin
            ce.inst  = k;
            ce.chk   = m_known[k];
            ce.we    = (m_mode[k] == M_LOAD) && load_vld && (load_addr < depth[k]);
            ce.addr  = (m_mode[k] == M_LOAD) ? load_addr : 24'(m_pc[k]);
            ce.wdat  = load_dat;
            ce.fetch = (m_mode[k] == M_RUN) && !stall && (m_pc[k] < depth[k]);
            cq.push_back(ce);
            advance(k);
            re.inst  = k;
            re.chk   = m_known[k];
            re.state = 2'(m_mode[k]);
            re.pc    = 24'(m_pc[k]);
            re.cnt   = 24'(m_cnt[k]);
            re.fault = m_fault[k];
            rq.push_back(re);
        end
        @(negedge clk);
    endtask

    task automatic idle();
        load_vld  = 1'b0; load_addr = '0; load_dat = '0; load_done = 1'b0;
        load_req  = 1'b0; stall = 1'b0; br = 1'b0; br_tgt = '0;
        halt      = 1'b0; resume = 1'b0;
    endtask

    initial begin : mon_comb
        comb_e e;
        forever begin
            @(negedge clk);
            #2;
            while (cq.size() > 0) begin
                e = cq.pop_front();
                if (e.chk) begin
                    check("imem_we",    e.inst, (e.inst == 0) ? o0_we    : o1_we,    e.we);
                    check("imem_addr",  e.inst, (e.inst == 0) ? o0_addr  : o1_addr,  e.addr);
                    check("imem_wdat",  e.inst, (e.inst == 0) ? o0_wdat  : o1_wdat,  e.wdat);
                    check("fetch_vld",  e.inst, (e.inst == 0) ? o0_fetch : o1_fetch, e.fetch);
                end
            end
        end
    end

    initial begin : mon_reg
        reg_e e;
        forever begin
            @(posedge clk);
            #1;
            while (rq.size() > 0) begin
                e = rq.pop_front();
                if (e.chk) begin
                    check("state",      e.inst, (e.inst == 0) ? o0_state : o1_state, e.state);
                    check("pc",         e.inst, (e.inst == 0) ? o0_pc    : o1_pc,    e.pc);
                    check("load_count", e.inst, (e.inst == 0) ? o0_cnt   : o1_cnt,   e.cnt);
                    check("addr_fault", e.inst, (e.inst == 0) ? o0_fault : o1_fault, e.fault);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        idle();
        @(negedge clk);

        // Reset
        step(); step();
        check("rst_state", 0, o0_state, 2'b00);
        check("rst_pc", 0, o0_pc, 0);
        check("rst_cnt", 0, o0_cnt, 0);
        check("rst_fault", 0, o0_fault, 0);
        check("rst_we", 0, o0_we, 0);
        rst_n = 1'b1;

        // Load four words then run
        for (int i = 0; i < 4; i++) begin
            load_vld = 1'b1; load_addr = 24'(i); load_dat = 24'hA00001 + 24'(i);
            step();
        end
        load_vld = 1'b0; load_done = 1'b1;
        step();
        load_done = 1'b0;
        check("load_cnt4", 0, o0_cnt, 4);
        check("run_state", 0, o0_state, 2'b01);
        check("run_pc0", 0, o0_pc, 0);
        repeat (4) step();
        check("run_pc4", 0, o0_pc, 4);

        // Stall / branch
        step();
        stall = 1'b1; step(); step();
        check("stall_pc", 0, o0_pc, 5);
        br = 1'b1; br_tgt = 24'd40; step();
        check("stall_br_pc", 0, o0_pc, 5);
        stall = 1'b0; step();
        check("branch_pc", 0, o0_pc, 40);

        // Halt beats branch, resume continues from held PC
        br_tgt = 24'd10; step();
        halt = 1'b1; br_tgt = 24'd99; step();
        halt = 1'b0; br = 1'b0;
        check("halt_state", 0, o0_state, 2'b10);
        check("halt_pc", 0, o0_pc, 10);
        check("halt_fetch", 0, o0_fetch, 0);
        resume = 1'b1; step(); resume = 1'b0;
        check("resume_pc", 0, o0_pc, 10);
        step();
        check("resume_pc_inc", 0, o0_pc, 11);

        // Range fault on the depth-16 instance
        rst_n = 1'b0; step(); rst_n = 1'b1;
        load_done = 1'b1; step(); load_done = 1'b0;
        repeat (16) step();
        check("fault_pc", 1, o1_pc, 16);
        check("fault_flag", 1, o1_fault, 1);
        check("fault_state", 1, o1_state, 2'b10);
        check("nofault_pc", 0, o0_pc, 16);
        load_req = 1'b1; step(); load_req = 1'b0;
        load_vld = 1'b1; load_addr = 24'd20; load_dat = 24'h123456;
        #1;
        check("oob_we", 1, o1_we, 0);
        step();
        load_vld = 1'b0;
        check("oob_fault", 1, o1_fault, 1);
        check("oob_cnt", 1, o1_cnt, 0);

        // Reset mid-LOAD and mid-RUN, then LoadReq beats Resume
        rst_n = 1'b0; step(); rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            load_vld = 1'b1; load_addr = 24'(i); step();
        end
        load_vld = 1'b0;
        check("mid_cnt3", 0, o0_cnt, 3);
        rst_n = 1'b0; step(); rst_n = 1'b1;
        check("rst_load_cnt", 0, o0_cnt, 0);
        check("rst_load_state", 0, o0_state, 2'b00);
        check("rst_fault_clr", 1, o1_fault, 0);
        load_done = 1'b1; step(); load_done = 1'b0;
        repeat (7) step();
        check("mid_pc7", 0, o0_pc, 7);
        rst_n = 1'b0; step(); rst_n = 1'b1;
        check("rst_run_pc", 0, o0_pc, 0);
        check("rst_run_state", 0, o0_state, 2'b00);
        load_done = 1'b1; step(); load_done = 1'b0;
        halt = 1'b1; step(); halt = 1'b0;
        load_req = 1'b1; resume = 1'b1; step();
        load_req = 1'b0; resume = 1'b0;
        check("req_wins", 0, o0_state, 2'b00);

        // Randomized traffic
        repeat (3000) begin
            rst_n     = ($urandom_range(0, 63) != 0);
            load_vld  = $urandom_range(0, 1) == 1;
            load_addr = ($urandom_range(0, 7) == 0) ? 24'($urandom_range(200, 300)) : 24'($urandom_range(0, 20));
            load_dat  = 24'($urandom);
            load_done = $urandom_range(0, 7) == 0;
            load_req  = $urandom_range(0, 7) == 0;
            resume    = $urandom_range(0, 3) == 0;
            stall     = $urandom_range(0, 3) == 0;
            br        = $urandom_range(0, 3) == 0;
            br_tgt    = ($urandom_range(0, 7) == 0) ? 24'($urandom) : 24'($urandom_range(0, 20));
            halt      = $urandom_range(0, 15) == 0;
            step();
        end
        idle();
        step();

        n_tests++;
        if (cq.size() != 0 || rq.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d/%0d entries left, required 0/0", cq.size(), rq.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
